dac_tlv5618_sched: RTL and testbench

Update scheduler in front of the TLV5618 serial DAC word serializer. It accepts independent 12-bit code updates for DAC channel A and channel B from two requesters and builds the TLV5618 16-bit command words. It issues the words one at a time to the serializer and waits for each to finish. When both channels request in the same cycle, it emits the buffer-then-latch pair so that both outputs change simultaneously.

---
 rtl/dac_tlv5618_sched_if.sv | 26 ++
 rtl/dac_tlv5618_sched.sv | 117 +++++++++++
 tb/tb_dac_tlv5618_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dac_tlv5618_sched_if.sv
// Request/command bundle between the two DAC requesters, the scheduler and the TLV5618 serializer.
// Latency and backpressure are defined by the scheduler; this file only groups the signals.
interface dac_tlv5618_sched_if;
   logic        a_valid;
   logic [11:0] a_code;
   logic        a_ready;
   logic        b_valid;
   logic [11:0] b_code;
   logic        b_ready;
   logic        pwr_down;
   logic        dac_start;
   logic [15:0] dac_data;
   logic        dac_done;
   logic        busy;
   logic        err_timeout;

   modport slave (
      input  a_valid, a_code, b_valid, b_code, pwr_down, dac_done,
      output a_ready, b_ready, dac_start, dac_data, busy, err_timeout
   );

   modport master (
      output a_valid, a_code, b_valid, b_code, pwr_down, dac_done,
      input  a_ready, b_ready, dac_start, dac_data, busy, err_timeout
   );
endinterface

// File: rtl/dac_tlv5618_sched.sv
// Schedules channel A/B code updates into TLV5618 command words, one word per serializer frame.
// Accept->dac_start is 1 cycle; requesters see ready only in IDLE, so they stall for the whole sequence.
module dac_tlv5618_sched #(
   parameter bit          SpdFast       = 1'b1,
   parameter int unsigned GapCycles     = 2,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   dac_tlv5618_sched_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

   localparam logic [15:0] TO_LAST  = 16'(TimeoutCycles - 2);
   localparam logic [7:0]  GAP_LAST = 8'(GapCycles - 1);

   state_t      state_q;
   logic [15:0] word1_q;
   logic        pend_q;
   logic        start_q;
   logic [15:0] data_q;
   logic        err_q;
   logic [15:0] to_cnt_q;
   logic [7:0]  gap_cnt_q;

   logic [15:0] seq0_d;
   logic [15:0] seq1_d;
   logic        pend_d;
   logic        accept;

   assign accept = bus.a_valid || bus.b_valid;

   // Word = {R1, SPD, PWR, R0, code}; a pair buffers B first so A_LATCH moves both outputs together.
   always_comb begin
      seq0_d = 16'h0000;
      seq1_d = 16'h0000;
      pend_d = 1'b0;
      if (bus.a_valid && bus.b_valid) begin
         seq0_d = {1'b0, SpdFast, bus.pwr_down, 1'b1, bus.b_code};
         seq1_d = {1'b1, SpdFast, bus.pwr_down, 1'b0, bus.a_code};
         pend_d = 1'b1;
      end else if (bus.a_valid) begin
         seq0_d = {1'b1, SpdFast, bus.pwr_down, 1'b0, bus.a_code};
      end else if (bus.b_valid) begin
         seq0_d = {1'b0, SpdFast, bus.pwr_down, 1'b0, bus.b_code};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         word1_q   <= 16'h0000;
         pend_q    <= 1'b0;
         start_q   <= 1'b0;
         data_q    <= 16'h0000;
         err_q     <= 1'b0;
         to_cnt_q  <= 16'h0000;
         gap_cnt_q <= 8'h00;
      end else begin
         start_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= ISSUE;
                  start_q <= 1'b1;
                  data_q  <= seq0_d;
                  word1_q <= seq1_d;
                  pend_q  <= pend_d;
               end
            end
            ISSUE: begin
               to_cnt_q <= 16'h0000;
               state_q  <= WAIT;
            end
            WAIT: begin
               if (bus.dac_done) begin
                  gap_cnt_q <= 8'h00;
                  state_q   <= GAP;
               end else if (to_cnt_q == TO_LAST) begin
                  // Abandon the rest of the sequence; the serializer is assumed stuck.
                  err_q     <= 1'b1;
                  pend_q    <= 1'b0;
                  gap_cnt_q <= 8'h00;
                  state_q   <= GAP;
               end else begin
                  to_cnt_q <= to_cnt_q + 16'd1;
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  if (pend_q) begin
                     state_q <= ISSUE;
                     start_q <= 1'b1;
                     data_q  <= word1_q;
                     pend_q  <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.a_ready     = (state_q == IDLE);
   assign bus.b_ready     = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.dac_start   = start_q;
   assign bus.dac_data    = data_q;
   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_dac_tlv5618_sched.sv
// Directed bench for dac_tlv5618_sched with a behavioural serializer answering dac_start after ser_lat cycles.
module tb_dac_tlv5618_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   rdy_bad = 0;
   logic ser_en = 1'b1;
   int   ser_lat = 4;

   int          st_cyc[$];
   logic [15:0] st_dat[$];
   int          er_cyc[$];
   int          dn_cyc[$];

   dac_tlv5618_sched_if ifc();

   dac_tlv5618_sched #(
      .SpdFast(1'b1),
      .GapCycles(2),
      .TimeoutCycles(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural serializer: done is driven from a falling edge so it lands in cycle start+ser_lat-1.
   initial begin
      ifc.dac_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && ser_en && ifc.dac_start) begin
            repeat (ser_lat - 1) @(negedge clk);
            ifc.dac_done = 1'b1;
            dn_cyc.push_back(cyc);
            @(negedge clk);
            ifc.dac_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.dac_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(ifc.dac_data);
         end
         if (ifc.err_timeout) er_cyc.push_back(cyc);
         if (ifc.a_ready !== !ifc.busy || ifc.b_ready !== !ifc.busy) rdy_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic clear_logs();
      st_cyc.delete();
      st_dat.delete();
      er_cyc.delete();
      dn_cyc.delete();
   endtask

   // Present a request for one accept edge; pwr_down flips afterwards to prove it was captured.
   task automatic req(input logic av, input logic bv, input logic [11:0] ac,
                      input logic [11:0] bc, input logic pd, input string tag);
      ifc.a_valid  = av;
      ifc.b_valid  = bv;
      ifc.a_code   = ac;
      ifc.b_code   = bc;
      ifc.pwr_down = pd;
      @(negedge clk);
      chk({tag, "_start"}, 32'(ifc.dac_start), 32'd1);
      ifc.a_valid  = 1'b0;
      ifc.b_valid  = 1'b0;
      ifc.pwr_down = ~pd;
   endtask

   task automatic wait_idle(input string tag, output int c);
      int n = 0;
      while (ifc.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle_bound"}, 32'(ifc.busy), 32'd0);
      c = cyc;
   endtask

   initial begin
      int idle_c;
      ifc.a_valid  = 1'b0;
      ifc.b_valid  = 1'b0;
      ifc.a_code   = 12'h000;
      ifc.b_code   = 12'h000;
      ifc.pwr_down = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",    32'(ifc.busy),        32'd0);
      chk("rst_start",   32'(ifc.dac_start),   32'd0);
      chk("rst_data",    32'(ifc.dac_data),    32'd0);
      chk("rst_err",     32'(ifc.err_timeout), 32'd0);
      chk("rst_a_ready", 32'(ifc.a_ready),     32'd1);
      chk("rst_b_ready", 32'(ifc.b_ready),     32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // A only
      clear_logs();
      ser_en = 1'b1; ser_lat = 4;
      req(1'b1, 1'b0, 12'h123, 12'h000, 1'b0, "a");
      wait_idle("a", idle_c);
      chk("a_nstart",  32'(st_cyc.size()), 32'd1);
      chk("a_data",    32'(st_dat[0]),     32'h0000C123);
      chk("a_busyfall", 32'(idle_c - dn_cyc[0]), 32'd3);
      chk("a_noerr",   32'(er_cyc.size()), 32'd0);

      // B only
      clear_logs();
      req(1'b0, 1'b1, 12'h000, 12'hABC, 1'b1, "b");
      wait_idle("b", idle_c);
      chk("b_nstart", 32'(st_cyc.size()), 32'd1);
      chk("b_data",   32'(st_dat[0]),     32'h00006ABC);

      // Simultaneous pair: start-to-start = ser_lat(4) + GapCycles(2)
      clear_logs();
      req(1'b1, 1'b1, 12'h800, 12'h400, 1'b0, "ab");
      wait_idle("ab", idle_c);
      chk("ab_nstart",  32'(st_cyc.size()), 32'd2);
      chk("ab_data0",   32'(st_dat[0]),     32'h00005400);
      chk("ab_data1",   32'(st_dat[1]),     32'h0000C800);
      chk("ab_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd6);
      chk("ab_done2st", 32'(st_cyc[1] - dn_cyc[0]), 32'd3);
      chk("ab_noerr",   32'(er_cyc.size()), 32'd0);

      // Timeout with the serializer silent
      clear_logs();
      ser_en = 1'b0;
      req(1'b1, 1'b1, 12'h111, 12'h222, 1'b0, "to");
      wait_idle("to", idle_c);
      chk("to_nerr",    32'(er_cyc.size()), 32'd1);
      chk("to_errtime", 32'(er_cyc[0] - st_cyc[0]), 32'd16);
      chk("to_nstart",  32'(st_cyc.size()), 32'd1);
      chk("to_gap",     32'(idle_c - er_cyc[0]), 32'd2);

      // done on the last WAIT cycle beats the timeout
      clear_logs();
      ser_en = 1'b1; ser_lat = 16;
      req(1'b1, 1'b1, 12'h333, 12'h444, 1'b0, "co");
      wait_idle("co", idle_c);
      chk("co_doneat",  32'(dn_cyc[0] - st_cyc[0]), 32'd15);
      chk("co_noerr",   32'(er_cyc.size()), 32'd0);
      chk("co_nstart",  32'(st_cyc.size()), 32'd2);
      chk("co_data1",   32'(st_dat[1]),     32'h0000C333);
      chk("co_done2st", 32'(st_cyc[1] - dn_cyc[0]), 32'd3);

      // Reset in WAIT of a pair, then a fresh B-only update
      clear_logs();
      ser_en = 1'b0;
      req(1'b1, 1'b1, 12'h555, 12'h666, 1'b0, "rw");
      repeat (4) @(negedge clk);
      chk("rw_busy_pre", 32'(ifc.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rw_start", 32'(ifc.dac_start), 32'd0);
      chk("rw_data",  32'(ifc.dac_data),  32'd0);
      chk("rw_busy",  32'(ifc.busy),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clear_logs();
      ser_en = 1'b1; ser_lat = 4;
      req(1'b0, 1'b1, 12'h000, 12'h777, 1'b0, "rb");
      wait_idle("rb", idle_c);
      repeat (4) @(negedge clk);
      chk("rb_nstart", 32'(st_cyc.size()), 32'd1);
      chk("rb_data",   32'(st_dat[0]),     32'h00004777);
      chk("rb_noerr",  32'(er_cyc.size()), 32'd0);

      chk("ready_track", 32'(rdy_bad), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
